// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with per-operand forwarding muxes,
// bubble injection (flush > ex_hold > stall > load) and saturating event counters.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] ID_RsData,
  input  logic [DATA_W-1:0] ID_RtData,
  input  logic [DATA_W-1:0] ID_RdData,
  input  logic [DATA_W-1:0] EX_Result,
  input  logic [DATA_W-1:0] MEM_Result,
  input  logic [1:0]        FW_Rs,
  input  logic [1:0]        FW_Rt,
  input  logic [1:0]        FW_Rd,
  input  logic              stall,
  input  logic              flush,
  input  logic              ex_hold,
  input  logic [4:0]        ID_Dst,
  input  logic              ID_Write,
  input  logic              ID_Float,
  input  logic [1:0]        ID_WBSrc,
  input  logic [3:0]        ID_AluOp,
  input  logic [DATA_W-1:0] ID_Imm,
  output logic [DATA_W-1:0] EX_Rs,
  output logic [DATA_W-1:0] EX_Rt,
  output logic [DATA_W-1:0] EX_Rd,
  output logic [DATA_W-1:0] EX_Imm,
  output logic [3:0]        EX_AluOp,
  output logic [4:0]        EX_Dst,
  output logic              EX_Write,
  output logic              EX_Float,
  output logic [1:0]        EX_WBSrc,
  output logic              EX_Valid,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);
  typedef struct packed {
    logic [DATA_W-1:0] rs;
    logic [DATA_W-1:0] rt;
    logic [DATA_W-1:0] rd;
    logic [DATA_W-1:0] imm;
    logic [3:0]        alu_op;
    logic [4:0]        dst;
    logic              wr;
    logic              fl;
    logic [1:0]        wb;
    logic              vld;
  } ex_t;
  ex_t ex_in, ex_d, ex_q;
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q, flush_cnt_d, flush_cnt_q;
  logic hold, load;
  function automatic logic [DATA_W-1:0] fwd(input logic [1:0] s, input logic [DATA_W-1:0] rf,
                                            input logic [DATA_W-1:0] ex, input logic [DATA_W-1:0] mem);
    return s == 2'd1 ? ex : s == 2'd2 ? mem : rf;
  endfunction
  always_comb begin
    hold  = !flush && ex_hold;
    load  = !flush && !ex_hold && !stall;
    ex_in = '{rs: fwd(FW_Rs, ID_RsData, EX_Result, MEM_Result),
              rt: fwd(FW_Rt, ID_RtData, EX_Result, MEM_Result),
              rd: fwd(FW_Rd, ID_RdData, EX_Result, MEM_Result),
              imm: ID_Imm, alu_op: ID_AluOp, dst: ID_Dst, wr: ID_Write,
              fl: ID_Float, wb: ID_WBSrc, vld: 1'b1};
    ex_d  = hold ? ex_q : load ? ex_in : '0;
    stall_cnt_d = (stall && !flush && !ex_hold && !(&stall_cnt_q)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    flush_cnt_d = (flush && !(&flush_cnt_q)) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
  assign EX_Rs     = ex_q.rs;
  assign EX_Rt     = ex_q.rt;
  assign EX_Rd     = ex_q.rd;
  assign EX_Imm    = ex_q.imm;
  assign EX_AluOp  = ex_q.alu_op;
  assign EX_Dst    = ex_q.dst;
  assign EX_Write  = ex_q.wr;
  assign EX_Float  = ex_q.fl;
  assign EX_WBSrc  = ex_q.wb;
  assign EX_Valid  = ex_q.vld;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: randomized + directed scoreboard bench; a 16-bit and a 4-bit counter instance share stimulus.
module tb_id_ex_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] ID_RsData = '0, ID_RtData = '0, ID_RdData = '0, EX_Result = '0, MEM_Result = '0, ID_Imm = '0;
  logic [1:0] FW_Rs = '0, FW_Rt = '0, FW_Rd = '0, ID_WBSrc = '0;
  logic stall = 1'b0, flush = 1'b0, ex_hold = 1'b0, ID_Write = 1'b0, ID_Float = 1'b0;
  logic [4:0] ID_Dst = '0;
  logic [3:0] ID_AluOp = '0;
  logic [31:0] EX_Rs, EX_Rt, EX_Rd, EX_Imm, d4_Rs, d4_Rt, d4_Rd, d4_Imm;
  logic [3:0] EX_AluOp, d4_AluOp;
  logic [4:0] EX_Dst, d4_Dst;
  logic EX_Write, EX_Float, EX_Valid, d4_Write, d4_Float, d4_Valid;
  logic [1:0] EX_WBSrc, d4_WBSrc;
  logic [15:0] stall_cnt, flush_cnt;
  logic [3:0] d4_stall_cnt, d4_flush_cnt;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .ID_RsData(ID_RsData), .ID_RtData(ID_RtData), .ID_RdData(ID_RdData),
    .EX_Result(EX_Result), .MEM_Result(MEM_Result), .FW_Rs(FW_Rs), .FW_Rt(FW_Rt), .FW_Rd(FW_Rd),
    .stall(stall), .flush(flush), .ex_hold(ex_hold), .ID_Dst(ID_Dst), .ID_Write(ID_Write),
    .ID_Float(ID_Float), .ID_WBSrc(ID_WBSrc), .ID_AluOp(ID_AluOp), .ID_Imm(ID_Imm),
    .EX_Rs(EX_Rs), .EX_Rt(EX_Rt), .EX_Rd(EX_Rd), .EX_Imm(EX_Imm), .EX_AluOp(EX_AluOp),
    .EX_Dst(EX_Dst), .EX_Write(EX_Write), .EX_Float(EX_Float), .EX_WBSrc(EX_WBSrc),
    .EX_Valid(EX_Valid), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

  id_ex_stage #(.DATA_W(32), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .ID_RsData(ID_RsData), .ID_RtData(ID_RtData), .ID_RdData(ID_RdData),
    .EX_Result(EX_Result), .MEM_Result(MEM_Result), .FW_Rs(FW_Rs), .FW_Rt(FW_Rt), .FW_Rd(FW_Rd),
    .stall(stall), .flush(flush), .ex_hold(ex_hold), .ID_Dst(ID_Dst), .ID_Write(ID_Write),
    .ID_Float(ID_Float), .ID_WBSrc(ID_WBSrc), .ID_AluOp(ID_AluOp), .ID_Imm(ID_Imm),
    .EX_Rs(d4_Rs), .EX_Rt(d4_Rt), .EX_Rd(d4_Rd), .EX_Imm(d4_Imm), .EX_AluOp(d4_AluOp),
    .EX_Dst(d4_Dst), .EX_Write(d4_Write), .EX_Float(d4_Float), .EX_WBSrc(d4_WBSrc),
    .EX_Valid(d4_Valid), .stall_cnt(d4_stall_cnt), .flush_cnt(d4_flush_cnt));

  typedef struct packed {
    logic [127:0] ops;
    logic [13:0]  ctrl;
    int sc, fc, sc4, fc4;
  } exp_t;

  exp_t q[$];
  exp_t m;
  int pass_cnt = 0, chk_cnt = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] pick(input logic [1:0] code, input logic [31:0] rf);
    if (code == 2'd1) return EX_Result;
    if (code == 2'd2) return MEM_Result;
    return rf;
  endfunction

  function automatic int sat(input int v, input int maxv);
    return v > maxv ? maxv : v;
  endfunction

  // Reference: what EX must show after the coming edge, given the inputs now applied.
  task automatic apply();
    if (flush || (!ex_hold && stall)) begin
      m.ops = '0;
      m.ctrl = '0;
    end else if (!ex_hold) begin
      m.ops  = {pick(FW_Rs, ID_RsData), pick(FW_Rt, ID_RtData), pick(FW_Rd, ID_RdData), ID_Imm};
      m.ctrl = {ID_AluOp, ID_Dst, ID_Write, ID_Float, ID_WBSrc, 1'b1};
    end
    if (stall && !flush && !ex_hold) begin
      m.sc  = sat(m.sc + 1, 65535);
      m.sc4 = sat(m.sc4 + 1, 15);
    end
    if (flush) begin
      m.fc  = sat(m.fc + 1, 65535);
      m.fc4 = sat(m.fc4 + 1, 15);
    end
    q.push_back(m);
  endtask

  task automatic rnd();
    ID_RsData = $urandom; ID_RtData = $urandom; ID_RdData = $urandom; ID_Imm = $urandom;
    EX_Result = $urandom; MEM_Result = $urandom;
    FW_Rs = 2'($urandom_range(0, 3)); FW_Rt = 2'($urandom_range(0, 3)); FW_Rd = 2'($urandom_range(0, 3));
    ID_Dst = 5'($urandom); ID_AluOp = 4'($urandom); ID_WBSrc = 2'($urandom);
    ID_Write = 1'($urandom); ID_Float = 1'($urandom);
    stall = ($urandom_range(0, 3) == 0);
    flush = ($urandom_range(0, 7) == 0);
    ex_hold = ($urandom_range(0, 4) == 0);
  endtask

  task automatic ctl(input logic s, input logic f, input logic h);
    stall = s; flush = f; ex_hold = h;
  endtask

  task automatic begin_step();
    @(negedge clk);
    rst_n = 1'b1;
    rnd();
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ops", {EX_Rs, EX_Rt, EX_Rd, EX_Imm}, '0);
    chk("rst_ctrl", {EX_AluOp, EX_Dst, EX_Write, EX_Float, EX_WBSrc, EX_Valid}, '0);
    chk("rst_cnt", {stall_cnt, flush_cnt}, '0);
    chk("rst_cnt4", {d4_stall_cnt, d4_flush_cnt}, '0);
    m = '0;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("ops", {EX_Rs, EX_Rt, EX_Rd, EX_Imm}, e.ops);
        chk("ctrl", {EX_AluOp, EX_Dst, EX_Write, EX_Float, EX_WBSrc, EX_Valid}, {114'd0, e.ctrl});
        chk("cnt", {stall_cnt, flush_cnt}, {96'd0, 16'(e.sc), 16'(e.fc)});
        chk("cnt4", {d4_stall_cnt, d4_flush_cnt}, {120'd0, 4'(e.sc4), 4'(e.fc4)});
        chk("wr_implies_vld", {127'd0, EX_Write & ~EX_Valid}, '0);
      end
    end
  end

  initial begin
    m = '0;
    #12;
    chk("init_ctrl", {EX_AluOp, EX_Dst, EX_Write, EX_Float, EX_WBSrc, EX_Valid}, '0);
    chk("init_cnt", {stall_cnt, flush_cnt}, '0);
    begin_step(); ctl(0, 0, 0);
    FW_Rs = 0; FW_Rt = 0; FW_Rd = 0; ID_RsData = 32'h11; ID_Dst = 5'd5; ID_Write = 1; ID_WBSrc = 0;
    apply();
    begin_step(); ctl(0, 0, 0);
    FW_Rs = 1; FW_Rt = 2; FW_Rd = 3; EX_Result = 32'hAAAA; MEM_Result = 32'h5555; ID_RdData = 32'h77;
    apply();
    repeat (2) begin begin_step(); ctl(1, 0, 0); ID_Write = 1; apply(); end
    begin_step(); ctl(0, 0, 0); apply();
    begin_step(); ctl(1, 1, 1); apply();
    begin_step(); ctl(0, 0, 0); apply();
    repeat (3) begin begin_step(); ctl(0, 0, 1); apply(); end
    repeat (3) begin begin_step(); ctl(1, 0, 1); apply(); end
    repeat (20) begin begin_step(); ctl(1, 0, 0); apply(); end
    begin_step(); ctl(0, 0, 0); apply();
    repeat (400) begin begin_step(); apply(); end
    begin_step(); ctl(0, 0, 0); ID_Write = 1; apply();
    do_reset();
    repeat (300) begin begin_step(); apply(); end
    repeat (3) @(negedge clk);
    chk("queue_drained", 128'(q.size()), '0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register plus ID-stage operand forwarding muxes; sits directly downstream of the forwarding unit.
- Consumes FW_Rs/FW_Rt/FW_Rd select codes and the load-use stall flag to pick each operand from the register file, the EX result or the MEM result.
- Either latches the decoded instruction into EX or injects a bubble.
- Drives EX_Dst/EX_Write/EX_Float/EX_WBSrc back to the forwarding unit; keeps saturating stall/bubble event counters.

Parameters:
- DATA_W, 32, operand/result width
- CNT_W, 16, width of each event counter

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ID_RsData, ID_RtData, ID_RdData  in  DATA_W each  register-file read data
- EX_Result  in  DATA_W  ALU result of instruction in EX (FW code 1)
- MEM_Result  in  DATA_W  result in MEM stage (FW code 2)
- FW_Rs, FW_Rt, FW_Rd  in  2 each  forward select: 0 regfile, 1 EX, 2 MEM, 3 reserved
- stall  in  1  load-use stall from forwarding unit
- flush  in  1  branch/jump squash of the instruction in ID
- ex_hold  in  1  EX busy (multicycle op); freeze this register
- ID_Dst  in  5  destination register
- ID_Write, ID_Float  in  1 each  register-write enable; FP destination
- ID_WBSrc  in  2  writeback source (1 = load)
- ID_AluOp  in  4  ALU operation
- ID_Imm  in  DATA_W  sign-extended immediate
- EX_Rs, EX_Rt, EX_Rd  out  DATA_W each  latched operands
- EX_Imm  out  DATA_W  latched immediate
- EX_AluOp  out  4  latched ALU op
- EX_Dst  out  5  latched destination (to forwarding unit)
- EX_Write, EX_Float  out  1 each  latched controls (to forwarding unit)
- EX_WBSrc  out  2  latched writeback source (to forwarding unit)
- EX_Valid  out  1  1 = real instruction, 0 = bubble
- stall_cnt, flush_cnt  out  CNT_W each  saturating event counters

Behaviour:
- Reset (rst_n low, async): all outputs 0, including data, counters and EX_Valid; held while low. Reset mid-operation discards the in-flight instruction; first edge after release follows the normal rules.
- Forward muxes, combinational, per operand: code 0 or 3 selects ID_*Data; 1 selects EX_Result; 2 selects MEM_Result. Codes are independent per operand; several operands may forward simultaneously.
- Per rising edge, priority flush > ex_hold > stall > load:
  - flush: bubble.
  - ex_hold (no flush): every register keeps its value; counters unchanged.
  - stall (no flush, no hold): bubble.
  - otherwise: latch muxed operands, ID_Imm, ID_AluOp, ID_Dst, ID_Write, ID_Float, ID_WBSrc; EX_Valid=1.
- Bubble: EX_Write=0, EX_Float=0, EX_WBSrc=0, EX_Dst=0, EX_AluOp=0, EX_Valid=0. Data outputs also cleared to 0 so the bubble is deterministic.
- Latency: one cycle from ID inputs to EX_* outputs. Forward select and data are sampled in the same cycle.
- stall_cnt increments when stall=1, flush=0, ex_hold=0.
- flush_cnt increments when flush=1, independent of ex_hold.
- Both counters saturate at all-ones; no wrap.
- Invariant: EX_Write=1 implies EX_Valid=1.
- Asserting stall on consecutive cycles produces consecutive bubbles. The upstream IF/ID hold is not this block's responsibility.

Test Plan:
- Reset: drive inputs nonzero, pulse rst_n low mid-cycle -> all outputs 0 immediately (async), counters 0.
- Plain load: FW all 0, ID_RsData=0x11, ID_Dst=5, ID_Write=1, ID_WBSrc=0 -> next edge: EX_Rs=0x11, EX_Dst=5, EX_Write=1, EX_Valid=1.
- Forward mix: FW_Rs=1, FW_Rt=2, FW_Rd=3, EX_Result=0xAAAA, MEM_Result=0x5555, ID_RdData=0x77 -> EX_Rs=0xAAAA, EX_Rt=0x5555, EX_Rd=0x77.
- Stall: stall=1 for 2 cycles with ID_Write=1 -> 2 bubbles (EX_Write=0, EX_Valid=0), stall_cnt=2; third cycle loads normally.
- Priority: flush=1, stall=1, ex_hold=1 together -> bubble, flush_cnt+1, stall_cnt unchanged. Then ex_hold=1 alone -> outputs frozen for the held cycles, counters unchanged.
- Saturation: CNT_W=4, hold stall=1 for 20 cycles -> stall_cnt sticks at 15.
